wdt_cmd_arbiter: RTL and testbench

Shares the watchdog timer's three configuration channels (WDEN, WDLIVE, WTOCNT) between several on-chip requesters, such as the CPU wrapper, a debug port and a DMA kicker. It arbitrates round-robin and issues one command at a time to the WDT through a valid/ready interface, then returns a per-requester response. It enforces an enable/ownership policy so that a requester which does not own the WDT cannot disable it or retime it. The block sits in the WDT clock domain, between the requester-side FIFOs and the WDT core.

---
 rtl/wdt_cmd_arbiter.sv | 103 ++++++++++
 tb/tb_wdt_cmd_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/wdt_cmd_arbiter.sv
// wdt_cmd_arbiter: round-robin arbiter issuing WDEN/WDLIVE/WTOCNT commands to the WDT with an enable/ownership policy.
// Optional WDT_ARB_OWNER_LOCK_EN: only the requester that enabled the WDT may disable it.
module wdt_cmd_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_err,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              WDEN_valid,
  input  logic              WDEN_ready,
  output logic              WDEN,
  output logic              WDLIVE_valid,
  input  logic              WDLIVE_ready,
  output logic              WDLIVE,
  output logic              WTOCNT_valid,
  input  logic              WTOCNT_ready,
  output logic [31:0]       WTOCNT,
  output logic              wdt_enabled,
  output logic [IDW-1:0]    owner_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t r_state, w_next;
  logic [IDW-1:0] r_g, r_last, w_g;
  logic [1:0] r_op, w_op;
  logic [31:0] r_data, w_data;
  logic [NREQ-1:0] w_sel;
  logic r_err, w_found, w_illegal, w_lock, w_hs, w_rsp_hs;
  // Pass 0 scans indices above last_grant, pass 1 wraps to the rest.
  always_comb begin
    w_found = 1'b0;
    w_g = '0;
    w_op = '0;
    w_data = '0;
    w_sel = '0;
    for (int p = 0; p < 2; p++)
      for (int j = 0; j < NREQ; j++)
        if (!w_found && req_valid[j] && ((p == 0) == (IDW'(j) > r_last))) begin
          w_found = 1'b1;
          w_g = IDW'(j);
          w_op = req_op[2*j +: 2];
          w_data = req_data[32*j +: 32];
          w_sel[j] = 1'b1;
        end
  end
`ifdef WDT_ARB_OWNER_LOCK_EN
  assign w_lock = w_op == 2'd0 && !w_data[0] && wdt_enabled && w_g != owner_id;
`else
  assign w_lock = 1'b0;
`endif
  assign w_illegal = w_op == 2'd3 || (w_op == 2'd2 && (wdt_enabled || w_data == '0)) ||
                     (w_op == 2'd1 && !wdt_enabled) || w_lock;
  assign WDEN_valid   = r_state == ISSUE && r_op == 2'd0;
  assign WDLIVE_valid = r_state == ISSUE && r_op == 2'd1;
  assign WTOCNT_valid = r_state == ISSUE && r_op == 2'd2;
  assign WDEN   = r_data[0];
  assign WDLIVE = r_data[0];
  assign WTOCNT = r_data;
  assign w_hs = (WDEN_valid && WDEN_ready) || (WDLIVE_valid && WDLIVE_ready) || (WTOCNT_valid && WTOCNT_ready);
  always_comb begin
    rsp_valid = '0;
    for (int j = 0; j < NREQ; j++) rsp_valid[j] = r_state == RESP && r_g == IDW'(j);
  end
  assign rsp_err  = r_state == RESP && r_err;
  assign w_rsp_hs = |(rsp_valid & rsp_ready);
  always_comb begin
    req_ready = r_state == IDLE ? w_sel : '0;
    w_next = r_state == IDLE  ? (w_found ? (w_illegal ? RESP : ISSUE) : IDLE) :
             r_state == ISSUE ? (w_hs ? RESP : ISSUE) :
             (w_rsp_hs ? IDLE : RESP);
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      r_state <= IDLE;
      r_g <= '0;
      r_op <= '0;
      r_data <= '0;
      r_err <= 1'b0;
      r_last <= IDW'(NREQ - 1);
      wdt_enabled <= 1'b0;
      owner_id <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_found) begin
        r_g <= w_g;
        r_op <= w_op;
        r_data <= w_data;
        r_err <= w_illegal;
      end
      // Re-enabling an already enabled WDT keeps the original owner.
      if (WDEN_valid && WDEN_ready) begin
        wdt_enabled <= r_data[0];
        if (r_data[0] && !wdt_enabled) owner_id <= r_g;
      end
      if (r_state == RESP && w_rsp_hs) r_last <= r_g;
    end
endmodule

// File: tb/tb_wdt_cmd_arbiter.sv
// tb_wdt_cmd_arbiter: directed self-checking bench for wdt_cmd_arbiter (NREQ=4).
module tb_wdt_cmd_arbiter;
  logic clk = 1'b0;
  logic rstn;
  logic [3:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_op;
  logic [127:0] req_data;
  logic rsp_err, WDEN_valid, WDEN_ready, WDEN, WDLIVE_valid, WDLIVE_ready, WDLIVE;
  logic WTOCNT_valid, WTOCNT_ready, wdt_enabled;
  logic [31:0] WTOCNT;
  logic [1:0] owner_id;
  int n_tests = 0;
  int n_fail = 0;
  wdt_cmd_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .WDEN_valid(WDEN_valid), .WDEN_ready(WDEN_ready), .WDEN(WDEN),
    .WDLIVE_valid(WDLIVE_valid), .WDLIVE_ready(WDLIVE_ready), .WDLIVE(WDLIVE),
    .WTOCNT_valid(WTOCNT_valid), .WTOCNT_ready(WTOCNT_ready), .WTOCNT(WTOCNT),
    .wdt_enabled(wdt_enabled), .owner_id(owner_id)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cmd(input int g, input logic [1:0] op, input logic [31:0] d, input logic e);
    @(negedge clk);
    req_valid = 4'(1 << g);
    req_op = {4{op}};
    req_data = {4{d}};
    #1 check("req_ready", 32'(req_ready), 32'(1 << g));
    @(negedge clk);
    req_valid = '0;
    if (!e) begin
      check("ch_valid", 32'({WTOCNT_valid, WDLIVE_valid, WDEN_valid}), 32'(3'b001 << op));
      check("ch_data", op == 2'd2 ? WTOCNT : 32'(op == 2'd0 ? WDEN : WDLIVE), op == 2'd2 ? d : 32'(d[0]));
      @(negedge clk);
    end else
      check("ch_quiet", 32'({WTOCNT_valid, WDLIVE_valid, WDEN_valid}), 32'd0);
    check("rsp_valid", 32'(rsp_valid), 32'(1 << g));
    check("rsp_err", 32'(rsp_err), 32'(e));
    @(negedge clk);
  endtask
  initial begin
    rstn = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_data = '0;
    rsp_ready = 4'hF;
    WDEN_ready = 1'b1;
    WDLIVE_ready = 1'b1;
    WTOCNT_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_ch_valid", 32'({WTOCNT_valid, WDLIVE_valid, WDEN_valid}), 0);
    check("rst_data", {WTOCNT[29:0], WDLIVE, WDEN}, 0);
    check("rst_enabled", 32'(wdt_enabled), 0);
    check("rst_owner", 32'(owner_id), 0);
    rstn = 1'b1;
    cmd(1, 2'd2, 32'h100, 1'b0);
    cmd(1, 2'd0, 32'h1, 1'b0);
    check("en_enabled", 32'(wdt_enabled), 1);
    check("en_owner", 32'(owner_id), 1);
    cmd(1, 2'd1, 32'h1, 1'b0);
    cmd(0, 2'd2, 32'h50, 1'b1);
    cmd(2, 2'd3, 32'h0, 1'b1);
    cmd(3, 2'd1, 32'h1, 1'b0);
    @(negedge clk);
    req_valid = 4'hF;
    req_op = {4{2'd1}};
    req_data = {4{32'h1}};
    for (int k = 0; k < 4; k++) begin
      #1 check("rr_grant", 32'(req_ready), 32'(1 << k));
      @(negedge clk);
      req_valid[k] = 1'b0;
      check("rr_live", 32'(WDLIVE_valid), 1);
      @(negedge clk);
      check("rr_rsp", 32'(rsp_valid), 32'(1 << k));
      @(negedge clk);
    end
`ifdef WDT_ARB_OWNER_LOCK_EN
    cmd(2, 2'd0, 32'h0, 1'b1);
    check("lock_enabled", 32'(wdt_enabled), 1);
    cmd(1, 2'd0, 32'h0, 1'b0);
`else
    cmd(2, 2'd0, 32'h0, 1'b0);
`endif
    check("dis_enabled", 32'(wdt_enabled), 0);
    check("dis_owner", 32'(owner_id), 1);
    cmd(0, 2'd1, 32'h1, 1'b1);
    cmd(0, 2'd2, 32'h0, 1'b1);
    @(negedge clk);
    WTOCNT_ready = 1'b0;
    req_valid = 4'b1000;
    req_op = {4{2'd2}};
    req_data = {4{32'h1234}};
    #1 check("bp_grant", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(WTOCNT_valid), 1);
      check("bp_data", WTOCNT, 32'h1234);
      check("bp_no_rsp", 32'(rsp_valid), 0);
      @(negedge clk);
    end
    WTOCNT_ready = 1'b1;
    @(negedge clk);
    check("bp_rsp", 32'(rsp_valid), 32'h8);
    check("bp_err", 32'(rsp_err), 0);
    @(negedge clk);
    check("bp_rsp_hold", 32'(rsp_valid), 32'h8);
    rsp_ready = 4'hF;
    @(negedge clk);
    check("bp_rsp_done", 32'(rsp_valid), 0);
    WDEN_ready = 1'b0;
    req_valid = 4'b0001;
    req_op = {4{2'd0}};
    req_data = {4{32'h1}};
    #1 check("ri_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    check("ri_wden_valid", 32'(WDEN_valid), 1);
    rstn = 1'b0;
    @(negedge clk);
    check("ri_valid_cleared", 32'({WTOCNT_valid, WDLIVE_valid, WDEN_valid}), 0);
    check("ri_enabled", 32'(wdt_enabled), 0);
    check("ri_rsp", 32'(rsp_valid), 0);
    rstn = 1'b1;
    WDEN_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ri_no_rsp", 32'(rsp_valid), 0);
      check("ri_no_wden", 32'(WDEN_valid), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
